// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, start/done handshake.
// Optional build macro SERIAL_SUB_SATURATE_EN clamps an underflowing result to zero.

module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StRun  = 1'b1;

   logic [0:0]       state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             borrow_q;
   logic [CntW-1:0]  cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_out_q;

   logic             bit_d;
   logic             borrow_d;
   logic [WIDTH:0]   res_ext;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] diff_d;
   logic             last_bit;

   always_comb begin
      bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;
      borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
      res_ext  = {bit_d, res_q};
      res_d    = res_ext[WIDTH:1];
      last_bit = (cnt_q == CntW'(WIDTH - 1));
`ifdef SERIAL_SUB_SATURATE_EN
      diff_d   = borrow_d ? '0 : res_d;
`else
      diff_d   = res_d;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         a_q          <= '0;
         b_q          <= '0;
         res_q        <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  res_q    <= '0;
                  borrow_q <= 1'b0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               res_q    <= res_d;
               borrow_q <= borrow_d;
               cnt_q    <= cnt_q + 1'b1;
               if (last_bit) begin
                  diff_q       <= diff_d;
                  borrow_out_q <= borrow_d;
                  done_q       <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances, vector tables,
// random operands against an arithmetic reference, and handshake corner sequences.

module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8, done8, bo8;
   logic [7:0] diff8;
   logic       start1 = 1'b0;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       busy1, done1, bo1;
   logic [0:0] diff1;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] exp_last = '0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference: plain unsigned arithmetic on integers.
   function automatic void model(input int unsigned a, input int unsigned b,
                                 input int unsigned w, output logic [7:0] d, output logic bo);
      int unsigned m;
      m  = (1 << w) - 1;
      bo = (a < b);
      d  = 8'((a - b) & m);
`ifdef SERIAL_SUB_SATURATE_EN
      if (bo) d = '0;
`endif
   endfunction

   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input string tag);
      logic [7:0] ed;
      logic       eb;
      model(ta, tb, 8, ed, eb);
      a8 = ta; b8 = tb; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = ~ta; b8 = ~tb;
      check({tag, "_start"}, {busy8, done8}, 2'b10);
      for (int i = 1; i < 8; i++) begin
         tick();
         check({tag, "_run"}, {busy8, done8}, 2'b10);
         if (i == 4) check({tag, "_hold"}, {bo8, diff8}, {1'b0, exp_last} | {bo8 === 1'b1, 8'h0} & 9'h100);
      end
      tick();
      check({tag, "_done"}, {busy8, done8}, 2'b01);
      check({tag, "_diff"}, diff8, ed);
      check({tag, "_borrow"}, bo8, eb);
      exp_last = ed;
      tick();
      check({tag, "_pulse"}, done8, 1'b0);
   endtask

   initial begin
      vec_t tab8 [6];
      vec_t tab1 [4];
      logic [7:0] ed, ed2;
      logic       eb, eb2;
      int         ndone;
      int         dtimes[$];

`ifdef SERIAL_SUB_SATURATE_EN
      tab8[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
      tab8[1] = '{8'h00, 8'h01, 8'h00, 1'b1};
      tab8[2] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      tab8[3] = '{8'h03, 8'h05, 8'h00, 1'b1};
      tab8[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tab8[5] = '{8'h00, 8'hFF, 8'h00, 1'b1};
      tab1[1] = '{8'h0, 8'h1, 8'h0, 1'b1};
`else
      tab8[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
      tab8[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
      tab8[2] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      tab8[3] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      tab8[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tab8[5] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      tab1[1] = '{8'h0, 8'h1, 8'h1, 1'b1};
`endif
      tab1[0] = '{8'h0, 8'h0, 8'h0, 1'b0};
      tab1[2] = '{8'h1, 8'h0, 8'h1, 1'b0};
      tab1[3] = '{8'h1, 8'h1, 8'h0, 1'b0};

      // Reset state, with start already requested to show it is not taken during reset
      start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
      tick(); tick();
      check("rst_dut8", {busy8, done8, bo8, diff8}, 11'h0);
      check("rst_dut1", {busy1, done1, bo1, diff1}, 4'h0);
      start8 = 1'b0;
      rst_n = 1'b1;
      tick();
      check("rst_idle", {busy8, done8}, 2'b00);

      foreach (tab8[i]) op8(tab8[i].a, tab8[i].b, $sformatf("vec%0d", i));
      // Table entries also cross-checked against the reference
      foreach (tab8[i]) begin
         model(tab8[i].a, tab8[i].b, 8, ed, eb);
         check($sformatf("tabref%0d", i), {eb, ed}, {tab8[i].bo, tab8[i].d});
      end

      for (int i = 0; i < 24; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = (i % 6 == 5) ? ra : 8'($urandom);
         op8(ra, rb, $sformatf("rnd%0d", i));
      end

      // Start during busy: second request must be dropped
      a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 === 1'b1) begin
            ndone++;
            check("busy_ign_diff", {bo8, diff8}, {1'b0, 8'h0F});
         end
      end
      check("busy_ign_ndone", ndone, 1);
      check("busy_ign_idle", busy8, 1'b0);
      exp_last = 8'h0F;

      // Back-to-back with start held high
      model(8'h80, 8'h7F, 8, ed, eb);
      model(8'h03, 8'h05, 8, ed2, eb2);
      a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
      tick();
      a8 = 8'h03; b8 = 8'h05;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 9) begin
            check("b2b_accept", {busy8, done8}, 2'b10);
            start8 = 1'b0;
         end
         if (done8 === 1'b1) begin
            if (dtimes.size() == 0) check("b2b_first", {bo8, diff8}, {eb, ed});
            else check("b2b_second", {bo8, diff8}, {eb2, ed2});
            dtimes.push_back(c);
         end
      end
      check("b2b_ndone", dtimes.size(), 2);
      if (dtimes.size() == 2) check("b2b_spacing", dtimes[1] - dtimes[0], 9);
      exp_last = ed2;

      // Reset mid-operation
      a8 = 8'h44; b8 = 8'h22; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      check("midrst_clear", {busy8, done8, bo8, diff8}, 11'h0);
      tick(); tick();
      rst_n = 1'b1;
      exp_last = '0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 === 1'b1) ndone++;
      end
      check("midrst_nodone", ndone, 0);
      check("midrst_held", {bo8, diff8}, 9'h0);
      op8(8'h44, 8'h22, "midrst_redo");

      // WIDTH=1 exhaustive
      foreach (tab1[i]) begin
         a1 = tab1[i].a[0]; b1 = tab1[i].b[0]; start1 = 1'b1;
         tick();
         start1 = 1'b0;
         check($sformatf("w1_start%0d", i), {busy1, done1}, 2'b10);
         tick();
         check($sformatf("w1_done%0d", i), {busy1, done1}, 2'b01);
         check($sformatf("w1_res%0d", i), {diff1, bo1}, {tab1[i].d[0], tab1[i].bo});
         tick();
         check($sformatf("w1_pulse%0d", i), done1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
